// File: rtl/uart_cmd_pkg.sv
// Shared constants, state type and hex decode for the UART line-command parser.
package uart_cmd_pkg;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_L_UC = 8'h4C;
    localparam logic [7:0] ASCII_L_LC = 8'h6C;
    localparam logic [7:0] ASCII_C_UC = 8'h43;
    localparam logic [7:0] ASCII_C_LC = 8'h63;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GOT_L   = 3'd1,
        ST_GOT_ARG = 3'd2,
        ST_GOT_C   = 3'd3,
        ST_DISCARD = 3'd4
    } cmd_state_t;

    // Letters map via the low nibble: 'A'/'a' = x1 -> 1 + 9 = 10.
    function automatic logic [3:0] hex_nibble(input logic [7:0] b, output logic valid);
        logic [3:0] v;
        v     = 4'h0;
        valid = 1'b1;
        if (b >= 8'h30 && b <= 8'h39)
            v = b[3:0];
        else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
            v = b[3:0] + 4'd9;
        else
            valid = 1'b0;
        return v;
    endfunction

    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/uart_led_cmd_if.sv
// Received-byte stream from uart_rx into the command parser.
interface uart_led_cmd_if #(
    parameter int DATA_BITS = 8
);
    logic                 data_rdy_in;
    logic [DATA_BITS-1:0] rx_data_in;

    modport master (output data_rdy_in, output rx_data_in);
    modport slave  (input  data_rdy_in, input  rx_data_in);
endinterface

// File: rtl/uart_led_cmd.sv
// Line-oriented command parser: "L<hex>" sets LEDs, "C" clears the error
// counter; malformed or timed-out lines pulse err_out.
module uart_led_cmd
    import uart_cmd_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 34_720,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 sysclk_in,
    input  logic                 nrst_in,
    uart_led_cmd_if.slave        rx,
    output logic [3:0]           led_out,
    output logic                 cmd_ok_out,
    output logic                 err_out,
    output logic [ERR_CNT_W-1:0] err_cnt_out
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    cmd_state_t           r_state;
    logic                 r_rdy_d;
    logic [TW-1:0]        r_tmo_cnt;
    logic [3:0]           r_nib;
    logic [3:0]           r_led;
    logic                 r_ok;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    cmd_state_t           w_state_nxt;
    logic [DATA_BITS-1:0] w_byte;
    logic                 w_acc;
    logic                 w_term;
    logic                 w_is_l;
    logic                 w_is_c;
    logic                 w_hex_ok;
    logic [3:0]           w_hex;
    logic                 w_tmo_hit;
    logic                 w_ok;
    logic                 w_err;
    logic                 w_led_ld;
    logic                 w_cnt_clr;
    logic                 w_nib_ld;

    assign w_byte = rx.rx_data_in;
    assign w_acc  = rx.data_rdy_in & ~r_rdy_d;
    assign w_term = is_term(w_byte[7:0]);
    assign w_is_l = (w_byte[7:0] == ASCII_L_UC) || (w_byte[7:0] == ASCII_L_LC);
    assign w_is_c = (w_byte[7:0] == ASCII_C_UC) || (w_byte[7:0] == ASCII_C_LC);

    always_comb begin
        w_hex_ok = 1'b0;
        w_hex    = hex_nibble(w_byte[7:0], w_hex_ok);
    end

    // Fires on the cycle the counter would reach TIMEOUT_CYCLES-1, so the
    // registered err_out lands exactly TIMEOUT_CYCLES cycles after the byte.
    assign w_tmo_hit = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 2));

    always_comb begin
        w_state_nxt = r_state;
        w_ok        = 1'b0;
        w_err       = 1'b0;
        w_led_ld    = 1'b0;
        w_cnt_clr   = 1'b0;
        w_nib_ld    = 1'b0;
        if (w_acc) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_l)      w_state_nxt = ST_GOT_L;
                    else if (w_is_c) w_state_nxt = ST_GOT_C;
                    else if (w_term) w_state_nxt = ST_IDLE;
                    else             w_state_nxt = ST_DISCARD;
                end
                ST_GOT_L: begin
                    if (w_hex_ok) begin
                        w_state_nxt = ST_GOT_ARG;
                        w_nib_ld    = 1'b1;
                    end else if (w_term) begin
                        w_state_nxt = ST_IDLE;
                        w_err       = 1'b1;
                    end else begin
                        w_state_nxt = ST_DISCARD;
                    end
                end
                ST_GOT_ARG: begin
                    if (w_term) begin
                        w_state_nxt = ST_IDLE;
                        w_led_ld    = 1'b1;
                        w_ok        = 1'b1;
                    end else begin
                        w_state_nxt = ST_DISCARD;
                    end
                end
                ST_GOT_C: begin
                    if (w_term) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_clr   = 1'b1;
                        w_ok        = 1'b1;
                    end else begin
                        w_state_nxt = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (w_term) begin
                        w_state_nxt = ST_IDLE;
                        w_err       = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (r_state != ST_IDLE && w_tmo_hit) begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
        end
    end

    always_ff @(posedge sysclk_in) begin
        if (!nrst_in) begin
            r_state   <= ST_IDLE;
            r_rdy_d   <= 1'b0;
            r_tmo_cnt <= '0;
            r_nib     <= 4'h0;
            r_led     <= 4'b1111;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rdy_d <= rx.data_rdy_in;
            r_ok    <= w_ok;
            r_err   <= w_err;
            if (w_acc || r_state == ST_IDLE)
                r_tmo_cnt <= '0;
            else
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_nib_ld)
                r_nib <= w_hex;
            if (w_led_ld)
                r_led <= r_nib;
            if (w_cnt_clr)
                r_err_cnt <= '0;
            else if (w_err && !(&r_err_cnt))
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign led_out     = r_led;
    assign cmd_ok_out  = r_ok;
    assign err_out     = r_err;
    assign err_cnt_out = r_err_cnt;

endmodule

// File: tb/tb_uart_led_cmd.sv
// Self-checking bench for uart_led_cmd: directed scenarios plus random lines
// checked against a line-level model of the command grammar.
module tb_uart_led_cmd;

    localparam int T  = 40;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          nrst;
    logic [3:0]    led;
    logic          ok;
    logic          err;
    logic [EW-1:0] errcnt;

    always #5 clk = ~clk;

    uart_led_cmd_if #(.DATA_BITS(8)) bus ();

    uart_led_cmd #(
        .DATA_BITS     (8),
        .TIMEOUT_CYCLES(T),
        .ERR_CNT_W     (EW)
    ) u_dut (
        .sysclk_in  (clk),
        .nrst_in    (nrst),
        .rx         (bus),
        .led_out    (led),
        .cmd_ok_out (ok),
        .err_out    (err),
        .err_cnt_out(errcnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Pulse monitor, sampled on the falling edge.
    int cyc = 0;
    int ok_seen = 0;
    int err_seen = 0;
    int last_err_cyc = -1;
    int acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ok === 1'b1) ok_seen <= ok_seen + 1;
        if (err === 1'b1) begin
            err_seen     <= err_seen + 1;
            last_err_cyc <= cyc;
        end
    end

    // Line-level reference model.
    int         m_led   = 15;
    int         m_errc  = 0;
    int         m_ok    = 0;
    int         m_errp  = 0;
    logic [7:0] line_q[$];

    function automatic bit m_is_hex(input logic [7:0] b);
        return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
    endfunction

    function automatic int m_hex_val(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        return int'(b) - 87;
    endfunction

    task automatic m_error();
        m_errp++;
        if (m_errc < 255) m_errc++;
    endtask

    task automatic m_eval_line();
        if (line_q.size() == 0) begin
        end else if (line_q.size() == 1 && (line_q[0] == "C" || line_q[0] == "c")) begin
            m_ok++;
            m_errc = 0;
        end else if (line_q.size() == 2 && (line_q[0] == "L" || line_q[0] == "l") && m_is_hex(line_q[1])) begin
            m_ok++;
            m_led = m_hex_val(line_q[1]);
        end else begin
            m_error();
        end
        line_q.delete();
    endtask

    task automatic m_byte(input logic [7:0] b);
        if (b == 8'h0D || b == 8'h0A) m_eval_line();
        else line_q.push_back(b);
    endtask

    task automatic m_timeout();
        if (line_q.size() != 0) m_error();
        line_q.delete();
    endtask

    task automatic m_reset();
        m_led  = 15;
        m_errc = 0;
        line_q.delete();
    endtask

    // Called at #1 after a rising edge; returns at #1 after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int hold);
        bus.data_rdy_in = 1'b1;
        bus.rx_data_in  = b;
        @(posedge clk); #1;
        acc_cyc = cyc;
        repeat (hold - 1) begin @(posedge clk); #1; end
        bus.data_rdy_in = 1'b0;
        bus.rx_data_in  = 8'($urandom);
        @(posedge clk); #1;
        m_byte(b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1);
    endtask

    task automatic do_reset(input int cycles);
        nrst = 1'b0;
        bus.data_rdy_in = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        nrst = 1'b1;
        m_reset();
    endtask

    task automatic test_reset();
        do_reset(3);
        n_chk++; if (led !== 4'b1111) begin n_fail++; $display("FAIL reset_led got %b want 1111", led); end
        n_chk++; if (ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok got %b want 0", ok); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        n_chk++; if (errcnt !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt got %0d want 0", errcnt); end
    endtask

    task automatic test_led_cmd();
        int ok0;
        ok0 = ok_seen;
        send_str("L5\r");
        n_chk++; if (led !== 4'b0101) begin n_fail++; $display("FAIL led_L5 got %b want 0101", led); end
        n_chk++; if (ok_seen != ok0 + 1) begin n_fail++; $display("FAIL ok_L5 got %0d want %0d", ok_seen, ok0 + 1); end
        n_chk++; if (errcnt !== 8'd0) begin n_fail++; $display("FAIL errcnt_L5 got %0d want 0", errcnt); end
        ok0 = ok_seen;
        send_str("lA\n\r\n");
        n_chk++; if (led !== 4'b1010) begin n_fail++; $display("FAIL led_lA got %b want 1010", led); end
        n_chk++; if (ok_seen != ok0 + 1) begin n_fail++; $display("FAIL ok_lA got %0d want %0d", ok_seen, ok0 + 1); end
    endtask

    task automatic test_errors();
        int e0;
        do_reset(1);
        e0 = err_seen;
        send_str("LG\rX123\n");
        n_chk++; if (err_seen != e0 + 2) begin n_fail++; $display("FAIL err_pulses got %0d want %0d", err_seen, e0 + 2); end
        n_chk++; if (errcnt !== 8'd2) begin n_fail++; $display("FAIL err_cnt2 got %0d want 2", errcnt); end
        n_chk++; if (led !== 4'b1111) begin n_fail++; $display("FAIL err_led got %b want 1111", led); end
    endtask

    task automatic test_timeout();
        int e0;
        int a;
        do_reset(1);
        e0 = err_seen;
        send_str("L7");
        a = acc_cyc;
        repeat (T + 5) @(posedge clk);
        #1;
        m_timeout();
        n_chk++; if (err_seen != e0 + 1) begin n_fail++; $display("FAIL tmo_pulses got %0d want %0d", err_seen, e0 + 1); end
        n_chk++; if (last_err_cyc != a + T - 1) begin n_fail++; $display("FAIL tmo_timing got cyc %0d want %0d", last_err_cyc, a + T - 1); end
        n_chk++; if (led !== 4'b1111) begin n_fail++; $display("FAIL tmo_led got %b want 1111", led); end
        n_chk++; if (errcnt !== 8'(m_errc)) begin n_fail++; $display("FAIL tmo_errcnt got %0d want %0d", errcnt, m_errc); end
        send_str("L7\r");
        n_chk++; if (led !== 4'b0111) begin n_fail++; $display("FAIL tmo_after_led got %b want 0111", led); end
    endtask

    task automatic test_saturate();
        int e0;
        int o0;
        do_reset(1);
        e0 = err_seen;
        for (int i = 0; i < 300; i++) begin
            case (i % 4)
                0: send_str("X\r");
                1: send_str("LG\n");
                2: send_str("L\r");
                default: send_str("C5\r");
            endcase
        end
        n_chk++; if (errcnt !== 8'd255) begin n_fail++; $display("FAIL sat_errcnt got %0d want 255", errcnt); end
        n_chk++; if (err_seen != e0 + 300) begin n_fail++; $display("FAIL sat_pulses got %0d want %0d", err_seen, e0 + 300); end
        o0 = ok_seen;
        send_str("c\r");
        n_chk++; if (errcnt !== 8'd0) begin n_fail++; $display("FAIL clr_errcnt got %0d want 0", errcnt); end
        n_chk++; if (ok_seen != o0 + 1) begin n_fail++; $display("FAIL clr_ok got %0d want %0d", ok_seen, o0 + 1); end
    endtask

    task automatic test_reset_mid();
        int e0;
        int o0;
        send_str("L5\r");
        send_str("X\r");
        send_str("L3");
        do_reset(1);
        n_chk++; if (led !== 4'b1111) begin n_fail++; $display("FAIL mid_led got %b want 1111", led); end
        n_chk++; if (errcnt !== 8'd0) begin n_fail++; $display("FAIL mid_errcnt got %0d want 0", errcnt); end
        n_chk++; if (ok !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL mid_pulses got ok=%b err=%b want 0 0", ok, err); end
        e0 = err_seen;
        o0 = ok_seen;
        send_str("\r");
        n_chk++; if (err_seen != e0) begin n_fail++; $display("FAIL mid_cr_err got %0d want %0d", err_seen, e0); end
        n_chk++; if (ok_seen != o0) begin n_fail++; $display("FAIL mid_cr_ok got %0d want %0d", ok_seen, o0); end
        n_chk++; if (led !== 4'b1111) begin n_fail++; $display("FAIL mid_cr_led got %b want 1111", led); end
    endtask

    // Random lines at mixed rates, including held-high data_rdy levels.
    task automatic test_back_to_back();
        string alpha;
        int    len;
        int    hold;
        alpha = "LlCc05aFfGX z9";
        for (int n = 0; n < 60; n++) begin
            len = $urandom_range(0, 3);
            for (int k = 0; k < len; k++) begin
                hold = $urandom_range(1, 3);
                send_byte(alpha[$urandom_range(0, alpha.len() - 1)], hold);
            end
            send_byte(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A, $urandom_range(1, 3));
            n_chk++; if (led !== 4'(m_led)) begin n_fail++; $display("FAIL rnd_led line %0d got %h want %h", n, led, m_led); end
            n_chk++; if (ok_seen != m_ok) begin n_fail++; $display("FAIL rnd_ok line %0d got %0d want %0d", n, ok_seen, m_ok); end
            n_chk++; if (err_seen != m_errp) begin n_fail++; $display("FAIL rnd_err line %0d got %0d want %0d", n, err_seen, m_errp); end
            n_chk++; if (errcnt !== 8'(m_errc)) begin n_fail++; $display("FAIL rnd_errcnt line %0d got %0d want %0d", n, errcnt, m_errc); end
        end
    endtask

    initial begin
        nrst = 1'b0;
        bus.data_rdy_in = 1'b0;
        bus.rx_data_in  = 8'h00;
        @(posedge clk); #1;
        test_reset();
        test_led_cmd();
        test_errors();
        m_ok   = ok_seen;
        m_errp = err_seen;
        test_timeout();
        test_saturate();
        test_reset_mid();
        m_ok   = ok_seen;
        m_errp = err_seen;
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
